// File: rtl/scpu_pkg.sv
// Shared SCPU definitions: RV32M funct3 encodings, MDU state encoding, datapath widths.
package scpu_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 5;
   localparam int unsigned ACC_W = 2 * XLEN;
   localparam int unsigned RD_W  = 5;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_CALC = 2'd1,
      MDU_FIX  = 2'd2,
      MDU_WB   = 2'd3
   } mdu_state_e;

   // Operation captured at launch and held for the whole iteration
   typedef struct packed {
      logic [2:0]      funct3;
      logic [RD_W-1:0] rd;
      logic            neg;
   } mdu_op_t;

   // Operand A is treated as two's complement for these ops
   function automatic logic op_a_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   // Operand B is treated as two's complement for these ops
   function automatic logic op_b_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on the shared accumulator.
module mdu_step
   import scpu_pkg::*;
(
   input  logic [ACC_W-1:0] acc_i,
   input  logic [XLEN-1:0]  opnd_i,
   input  logic             is_div_i,
   output logic [ACC_W-1:0] acc_next_c
);

   logic [XLEN:0] mul_hi;
   logic [XLEN:0] rem_shift;
   logic          rem_ge;

   // Multiply: {product_hi, multiplier} shifts right; divide: {remainder, quotient} shifts left
   always_comb begin
      mul_hi = {1'b0, acc_i[ACC_W-1:XLEN]};
      if (acc_i[0]) begin
         mul_hi = mul_hi + {1'b0, opnd_i};
      end
      rem_shift = {acc_i[ACC_W-1:XLEN], acc_i[XLEN-1]};
      rem_ge    = (rem_shift >= {1'b0, opnd_i});
      if (is_div_i) begin
         acc_next_c = {(rem_ge ? (rem_shift[XLEN-1:0] - opnd_i) : rem_shift[XLEN-1:0]),
                       acc_i[XLEN-2:0], rem_ge};
      end else begin
         acc_next_c = {mul_hi, acc_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: 32 radix-2 steps, sign fix, one-cycle writeback.
module mdu_iterative
   import scpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [RD_W-1:0] rd,
   output logic            busy,
   output logic            reg_write,
   output logic [RD_W-1:0] write_reg,
   output logic [XLEN-1:0] write_data
);

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [XLEN-1:0]  opnd_q, opnd_d;
   mdu_op_t          op_q, op_d;
   logic             busy_q, busy_d;
   logic             reg_write_q, reg_write_d;
   logic [RD_W-1:0]  write_reg_q, write_reg_d;
   logic [XLEN-1:0]  write_data_q, write_data_d;

   logic [ACC_W-1:0] acc_step_c;
   logic             sgn_a, sgn_b;
   logic [XLEN-1:0]  mag_a, mag_b;
   logic             div_zero, div_ovf;
   logic [ACC_W-1:0] prod;
   logic [XLEN-1:0]  quot, rem, result;

   mdu_step u_step (
      .acc_i      (acc_q),
      .opnd_i     (opnd_q),
      .is_div_i   (op_q.funct3[2]),
      .acc_next_c (acc_step_c)
   );

   // Next-state, datapath and registered-output logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      opnd_d       = opnd_q;
      op_d         = op_q;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;

      sgn_a    = op_a_signed(funct3) & rs1_data[XLEN-1];
      sgn_b    = op_b_signed(funct3) & rs2_data[XLEN-1];
      mag_a    = sgn_a ? (-rs1_data) : rs1_data;
      mag_b    = sgn_b ? (-rs2_data) : rs2_data;
      div_zero = funct3[2] && (rs2_data == '0);
      div_ovf  = funct3[2] && !funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (rs2_data == '1);

      prod = op_q.neg ? (-acc_q) : acc_q;
      quot = op_q.neg ? (-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
      rem  = op_q.neg ? (-acc_q[ACC_W-1:XLEN]) : acc_q[ACC_W-1:XLEN];
      case (op_q.funct3)
         F3_MUL:                           result = prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU:     result = prod[ACC_W-1:XLEN];
         F3_DIV, F3_DIVU:                  result = quot;
         default:                          result = rem;
      endcase

      case (state_q)
         MDU_IDLE: begin
            if (start && !flush) begin
               op_d.funct3 = funct3;
               op_d.rd     = rd;
               cnt_d       = CNT_W'(XLEN - 1);
               if (div_zero) begin
                  // Quotient all-ones, remainder is the raw dividend
                  acc_d    = {rs1_data, {XLEN{1'b1}}};
                  op_d.neg = 1'b0;
                  state_d  = MDU_FIX;
               end else if (div_ovf) begin
                  acc_d    = {{XLEN{1'b0}}, rs1_data};
                  op_d.neg = 1'b0;
                  state_d  = MDU_FIX;
               end else begin
                  acc_d    = {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
                  opnd_d   = funct3[2] ? mag_b : mag_a;
                  op_d.neg = (funct3[2] && funct3[1]) ? sgn_a : (sgn_a ^ sgn_b);
                  state_d  = MDU_CALC;
               end
            end
         end
         MDU_CALC: begin
            acc_d = acc_step_c;
            if (cnt_q == '0) begin
               state_d = MDU_FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         MDU_FIX: begin
            write_data_d = result;
            write_reg_d  = op_q.rd;
            state_d      = MDU_WB;
         end
         default: begin
            state_d = MDU_IDLE;
         end
      endcase

      // Abort drops the operation before anything reaches the write port
      if (flush && (state_q != MDU_IDLE)) begin
         state_d      = MDU_IDLE;
         write_reg_d  = write_reg_q;
         write_data_d = write_data_q;
      end

      busy_d      = (state_d != MDU_IDLE);
      reg_write_d = (state_d == MDU_WB) && (op_q.rd != '0);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= MDU_IDLE;
         cnt_q        <= '0;
         acc_q        <= '0;
         opnd_q       <= '0;
         op_q         <= '0;
         busy_q       <= 1'b0;
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         opnd_q       <= opnd_d;
         op_q         <= op_d;
         busy_q       <= busy_d;
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   assign busy       = busy_q;
   assign reg_write  = reg_write_q;
   assign write_reg  = write_reg_q;
   assign write_data = write_data_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: arithmetic/timing model checked every cycle plus literal results.
module tb_mdu_iterative;
   import scpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] rs1_data = 32'h0;
   logic [31:0] rs2_data = 32'h0;
   logic [4:0]  rd = 5'd0;
   logic        busy;
   logic        reg_write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;

   mdu_iterative dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .flush      (flush),
      .funct3     (funct3),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .rd         (rd),
      .busy       (busy),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   // Model of the single in-flight operation (driver side) and held write port (checker side)
   bit          checking = 1'b0;
   bit          m_active = 1'b0;
   int          m_start = 0;
   int          m_done = 0;
   int          m_end = 0;
   logic [31:0] m_data = 32'h0;
   logic [4:0]  m_rd = 5'd0;
   logic [31:0] held_data = 32'h0;
   logic [4:0]  held_reg = 5'd0;
   logic        exp_busy, exp_rw;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
   endtask

   // RV32M results straight from the ISA definition
   function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [63:0] sa, sb, ub_s, ps;
      logic [63:0]        ua, ub, pu;
      int                 ia, ib;
      sa   = {{32{a[31]}}, a};
      sb   = {{32{b[31]}}, b};
      ua   = {32'h0, a};
      ub   = {32'h0, b};
      ub_s = ub;
      ia   = a;
      ib   = b;
      case (f)
         F3_MUL:    begin pu = ua * ub;   return pu[31:0];  end
         F3_MULH:   begin ps = sa * sb;   return ps[63:32]; end
         F3_MULHSU: begin ps = sa * ub_s; return ps[63:32]; end
         F3_MULHU:  begin pu = ua * ub;   return pu[63:32]; end
         F3_DIV: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(ia / ib);
         end
         F3_DIVU: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            return a / b;
         end
         F3_REM: begin
            if (b == 32'h0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(ia % ib);
         end
         default: begin
            if (b == 32'h0) return a;
            return a % b;
         end
      endcase
   endfunction

   // Cycles from the start-sampling cycle to the writeback cycle
   function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && (b == 32'h0)) return 2;
      if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 34;
   endfunction

   // Per-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (!rst_n) begin
         held_data = 32'h0;
         held_reg  = 5'd0;
      end else if (m_active && cyc == m_done && m_end >= m_done) begin
         held_data = m_data;
         held_reg  = m_rd;
      end
      exp_busy = rst_n && m_active && (cyc > m_start) && (cyc <= m_end);
      exp_rw   = rst_n && m_active && (cyc == m_done) && (m_end >= m_done) && (m_rd != 5'd0);
      if (checking) begin
         check("cyc_busy", 32'(busy), 32'(exp_busy));
         check("cyc_reg_write", 32'(reg_write), 32'(exp_rw));
         check("cyc_write_reg", 32'(write_reg), 32'(held_reg));
         check("cyc_write_data", write_data, held_data);
      end
   end

   // Drive start for the current cycle once the unit is free, and record the expectation
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r);
      int guard = 0;
      while (m_active && cyc <= m_end && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 100) timeout("issue_wait");
      funct3   = f;
      rs1_data = a;
      rs2_data = b;
      rd       = r;
      start    = 1'b1;
      m_start  = cyc;
      m_done   = cyc + exp_lat(f, a, b);
      m_end    = m_done;
      m_data   = ref_res(f, a, b);
      m_rd     = r;
      m_active = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Wait for the writeback cycle and compare against a hand-computed literal
   task automatic wait_done(input string name, input logic [31:0] lit);
      int guard = 0;
      while (cyc < m_done && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 100) timeout({name, "_wait"});
      @(negedge clk);
      check({name, "_data"}, write_data, lit);
      check({name, "_rw"}, 32'(reg_write), 32'(m_rd != 5'd0));
      @(posedge clk); #1;
   endtask

   // Assert flush for one cycle, k cycles after the start-sampling cycle
   task automatic flush_at(input int k);
      int guard = 0;
      while (cyc < m_start + k && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 100) timeout("flush_wait");
      flush = 1'b1;
      if (m_active && cyc > m_start && cyc <= m_end) m_end = cyc;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_reg_write", 32'(reg_write), 32'h0);
      check("reset_write_reg", 32'(write_reg), 32'h0);
      check("reset_write_data", write_data, 32'h0);
      rst_n    = 1'b1;
      checking = 1'b1;
      @(posedge clk); #1;

      // Multiply family
      issue(F3_MUL, 32'd7, 32'd6, 5'd5);                     wait_done("mul_7x6", 32'd42);
      issue(F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);    wait_done("mulh_m1", 32'h0);
      issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);   wait_done("mulhu_max", 32'hFFFF_FFFE);
      issue(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);  wait_done("mulhsu", 32'hFFFF_FFFF);
      issue(F3_MULH, 32'hFFFF_FFFD, 32'd5, 5'd9);            wait_done("mulh_neg", 32'hFFFF_FFFF);
      issue(F3_MULHU, 32'h8000_0000, 32'd4, 5'd10);          wait_done("mulhu_bit", 32'd2);
      issue(F3_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11);    wait_done("mul_wrap", 32'd1);
      issue(F3_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12);    wait_done("mul_mix", m_data);
      issue(F3_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13); wait_done("mulhsu_min", m_data);

      // Divide family
      issue(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd14);            wait_done("div_m7_2", 32'hFFFF_FFFD);
      issue(F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd15);            wait_done("rem_m7_2", 32'hFFFF_FFFF);
      issue(F3_DIVU, 32'd100, 32'd7, 5'd16);                 wait_done("divu_100_7", 32'd14);
      issue(F3_REMU, 32'd100, 32'd7, 5'd17);                 wait_done("remu_100_7", 32'd2);
      issue(F3_DIV, 32'd7, 32'hFFFF_FFFE, 5'd18);            wait_done("div_7_m2", 32'hFFFF_FFFD);
      issue(F3_REM, 32'd7, 32'hFFFF_FFFE, 5'd19);            wait_done("rem_7_m2", 32'd1);
      issue(F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20);   wait_done("divu_big", 32'd0);
      issue(F3_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21);   wait_done("remu_big", 32'h8000_0000);

      // Shortcut cases
      issue(F3_DIV, 32'd5, 32'd0, 5'd22);                    wait_done("div_by0", 32'hFFFF_FFFF);
      issue(F3_REM, 32'd5, 32'd0, 5'd23);                    wait_done("rem_by0", 32'd5);
      issue(F3_REM, 32'hFFFF_FFF8, 32'd0, 5'd24);            wait_done("rem_neg_by0", 32'hFFFF_FFF8);
      issue(F3_DIVU, 32'd9, 32'd0, 5'd25);                   wait_done("divu_by0", 32'hFFFF_FFFF);
      issue(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd26);    wait_done("div_ovf", 32'h8000_0000);
      issue(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd27);    wait_done("rem_ovf", 32'h0);

      // Start while busy is ignored
      issue(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7);
      repeat (4) begin @(posedge clk); #1; end
      funct3 = F3_MUL; rs1_data = 32'd3; rs2_data = 32'd3; rd = 5'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("div_busy_start", 32'hFFFF_FFFD);

      // Flush mid-divide, then immediate restart
      issue(F3_DIV, 32'd1000, 32'd3, 5'd3);
      flush_at(10);
      check("flush_busy_next", 32'(busy), 32'h0);
      issue(F3_MUL, 32'd3, 32'd4, 5'd4);                     wait_done("mul_after_flush", 32'd12);

      // Flush in the writeback cycle still commits
      issue(F3_DIVU, 32'd100, 32'd7, 5'd3);
      flush_at(34);
      check("flush_wb_data", write_data, 32'd14);

      // Flush together with start while idle captures nothing
      funct3 = F3_MUL; rs1_data = 32'd2; rs2_data = 32'd2; rd = 5'd2;
      start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("flush_start_idle", 32'(busy), 32'h0);
      repeat (3) begin @(posedge clk); #1; end

      // Reset in the middle of an operation
      issue(F3_MUL, 32'h1234, 32'h10, 5'd4);
      while (cyc < m_start + 20) begin @(posedge clk); #1; end
      rst_n    = 1'b0;
      m_active = 1'b0;
      #1;
      check("rst_mid_busy", 32'(busy), 32'h0);
      check("rst_mid_reg_write", 32'(reg_write), 32'h0);
      check("rst_mid_write_data", write_data, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // rd == 0 runs but never strobes the write port
      issue(F3_MUL, 32'd9, 32'd9, 5'd0);                     wait_done("mul_rd0", 32'd81);
      issue(F3_DIVU, 32'd50, 32'd5, 5'd31);                  wait_done("divu_rd31", 32'd10);

      repeat (3) begin @(posedge clk); #1; end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
